// File: rtl/apb_pkg.sv
// Shared definitions for the APB subsystem: default bus widths and the
// request-arbiter state encoding.
package apb_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        XFER   = 2'd1,
        LOCKED = 2'd2
    } arb_state_t;

endpackage

// File: rtl/apb_req_arbiter_rr_picker.sv
// Combinational round-robin picker: the first set bit of req_vec_i at or
// after ptr_i (wrapping through N-1 back to 0) wins.
module rr_picker
    import apb_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_vec_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     grant_onehot_o,
    output logic [IDX_W-1:0] grant_idx_o,
    output logic             any_o
);

    // Scan from the farthest offset down to ptr so the nearest requester wins last.
    always_comb begin
        int idx;
        idx            = 0;
        grant_onehot_o = '0;
        grant_idx_o    = '0;
        any_o          = 1'b0;
        for (int off = N - 1; off >= 0; off--) begin
            idx = (int'(ptr_i) + off) % N;
            if (req_vec_i[idx]) begin
                grant_onehot_o      = '0;
                grant_onehot_o[idx] = 1'b1;
                grant_idx_o         = IDX_W'(idx);
                any_o               = 1'b1;
            end
        end
    end

endmodule

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter sharing the single request port of apb_master between
// NUM_REQ requesters, with a per-requester lock that keeps the grant across
// back-to-back transfers (e.g. read-modify-write sequences).
module apb_req_arbiter
    import apb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        m_valid,
    input  logic [NUM_REQ-1:0]        m_write,
    input  logic [NUM_REQ-1:0]        m_lock,
    input  logic [NUM_REQ*ADDR_W-1:0] m_addr,
    input  logic [NUM_REQ*DATA_W-1:0] m_wdata,
    output logic [NUM_REQ-1:0]        m_ready,
    output logic [DATA_W-1:0]         m_rdata,
    output logic                      m_error,
    output logic                      req_valid,
    output logic                      req_write,
    output logic [ADDR_W-1:0]         req_addr,
    output logic [DATA_W-1:0]         req_wdata,
    input  logic                      req_ready,
    input  logic [DATA_W-1:0]         req_rdata,
    input  logic                      req_error,
    output logic [IDX_W-1:0]          grant_id,
    output logic                      busy
);

    arb_state_t          state_q, state_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [IDX_W-1:0]    grant_q, grant_d;
    logic                req_valid_q, req_valid_d;
    logic                req_write_q, req_write_d;
    logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
    logic [DATA_W-1:0]   req_wdata_q, req_wdata_d;

    logic [NUM_REQ-1:0]  pick_onehot;
    logic [IDX_W-1:0]    pick_idx;
    logic                pick_any;
    logic                done;

    rr_picker #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .req_vec_i      (m_valid),
        .ptr_i          (ptr_q),
        .grant_onehot_o (pick_onehot),
        .grant_idx_o    (pick_idx),
        .any_o          (pick_any)
    );

    // Completion only counts while a transfer is outstanding; stray req_ready is ignored.
    assign done = (state_q == XFER) && req_ready;

    // Next-state logic: grant, capture command, hold or release the lock.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        grant_d     = grant_q;
        req_valid_d = req_valid_q;
        req_write_d = req_write_q;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    req_write_d = |(pick_onehot & m_write);
                    req_addr_d  = m_addr[int'(pick_idx) * ADDR_W +: ADDR_W];
                    req_wdata_d = m_wdata[int'(pick_idx) * DATA_W +: DATA_W];
                    grant_d     = pick_idx;
                    req_valid_d = 1'b1;
                    ptr_d       = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + IDX_W'(1);
                    state_d     = XFER;
                end
            end
            XFER: begin
                if (req_ready) begin
                    req_valid_d = 1'b0;
                    state_d     = m_lock[grant_q] ? LOCKED : IDLE;
                end
            end
            LOCKED: begin
                // The lock holder is served without moving the round-robin pointer.
                if (m_valid[grant_q]) begin
                    req_write_d = m_write[grant_q];
                    req_addr_d  = m_addr[int'(grant_q) * ADDR_W +: ADDR_W];
                    req_wdata_d = m_wdata[int'(grant_q) * DATA_W +: DATA_W];
                    req_valid_d = 1'b1;
                    state_d     = XFER;
                end else if (!m_lock[grant_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Response routing back to the granted requester, zero outside completion.
    always_comb begin
        m_ready = '0;
        m_rdata = '0;
        m_error = 1'b0;
        if (done) begin
            m_ready[grant_q] = 1'b1;
            m_rdata          = req_rdata;
            m_error          = req_error;
        end
    end

    // State and command registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            grant_q     <= '0;
            req_valid_q <= 1'b0;
            req_write_q <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            grant_q     <= grant_d;
            req_valid_q <= req_valid_d;
            req_write_q <= req_write_d;
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
        end
    end

    assign req_valid = req_valid_q;
    assign req_write = req_write_q;
    assign req_addr  = req_addr_q;
    assign req_wdata = req_wdata_q;
    assign grant_id  = grant_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Bench for apb_req_arbiter: requester/master stubs, a behavioural model
// checked every cycle, and directed scenarios with literal expectations.
module tb_apb_req_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 2;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    m_valid, m_write, m_lock, m_ready;
    logic [N*AW-1:0] m_addr;
    logic [N*DW-1:0] m_wdata;
    logic [DW-1:0]   m_rdata;
    logic            m_error;
    logic            req_valid, req_write, req_ready, req_error, busy;
    logic [AW-1:0]   req_addr;
    logic [DW-1:0]   req_wdata, req_rdata;
    logic [IW-1:0]   grant_id;

    apb_req_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .IDX_W(IW)) dut (
        .clk(clk), .rst_n(rst_n),
        .m_valid(m_valid), .m_write(m_write), .m_lock(m_lock),
        .m_addr(m_addr), .m_wdata(m_wdata),
        .m_ready(m_ready), .m_rdata(m_rdata), .m_error(m_error),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_ready(req_ready), .req_rdata(req_rdata),
        .req_error(req_error), .grant_id(grant_id), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests, n_fail;

    // requester jobs: per requester, up to 4 queued commands
    bit          job_wr   [N][4];
    bit          job_lock [N][4];
    logic [31:0] job_addr [N][4];
    logic [31:0] job_wdata[N][4];
    int          base[N], pending[N], done_total[N];
    int          grant_log[$];
    logic [31:0] last_rdata;
    logic        last_err;

    // APB master stub controls
    int          slv_delay, slv_cnt;
    logic [31:0] slv_rdata;
    logic        slv_err, slv_spur;

    // behavioural model
    int          md_st;   // 0 = nothing granted, 1 = transfer outstanding, 2 = grant held by lock
    int          md_ptr, md_gid, md_found;
    logic        md_rv, md_wr;
    logic [31:0] md_addr, md_wdata;
    logic [N-1:0] exp_ready;
    logic [31:0] exp_rdata;
    logic        exp_err;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #3;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic wait_all(input int budget, input string name);
        int  c;
        bit  ok;
        c  = 0;
        ok = 1'b0;
        while (!ok && c < budget) begin
            ok = (md_st == 0);
            for (int i = 0; i < N; i++) if (done_total[i] < pending[i]) ok = 1'b0;
            if (!ok) begin
                step();
                c++;
            end
        end
        chk(name, 64'(ok), 64'(1));
    endtask

    task automatic check_order(input string name, input int exp[$]);
        chk({name, "_len"}, 64'(grant_log.size()), 64'(exp.size()));
        for (int i = 0; i < exp.size() && i < grant_log.size(); i++)
            chk(name, 64'(grant_log[i]), 64'(exp[i]));
    endtask

    task automatic new_test();
        for (int i = 0; i < N; i++) begin
            base[i]    = done_total[i];
            pending[i] = done_total[i];
        end
        grant_log.delete();
    endtask

    task automatic set_job(input int r, input int k, input bit wr, input logic [31:0] a,
                           input logic [31:0] d, input bit lk);
        job_wr[r][k]    = wr;
        job_addr[r][k]  = a;
        job_wdata[r][k] = d;
        job_lock[r][k]  = lk;
    endtask

    initial begin
        int exp_q[$];
        n_tests = 0; n_fail = 0;
        rst_n = 1'b0;
        m_valid = '0; m_write = '0; m_lock = '0; m_addr = '0; m_wdata = '0;
        req_ready = 1'b0; req_rdata = '0; req_error = 1'b0;
        slv_delay = 1; slv_cnt = 0; slv_rdata = 32'h1234_5678; slv_err = 1'b0; slv_spur = 1'b0;
        md_st = 0; md_ptr = 0; md_gid = 0; md_rv = 0; md_wr = 0; md_addr = 0; md_wdata = 0;
        last_rdata = '0; last_err = 1'b0;
        for (int i = 0; i < N; i++) begin
            base[i] = 0; pending[i] = 0; done_total[i] = 0;
            for (int k = 0; k < 4; k++) set_job(i, k, 1'b0, 32'h0, 32'h0, 1'b0);
        end

        fork
            // model: advances at each active edge from the inputs seen there
            forever begin
                @(posedge clk);
                if (!rst_n) begin
                    md_st = 0; md_ptr = 0; md_gid = 0; md_rv = 0;
                    md_wr = 0; md_addr = 0; md_wdata = 0;
                end else if (md_st == 0) begin
                    md_found = -1;
                    for (int k = 0; k < N; k++)
                        if (md_found < 0 && m_valid[(md_ptr + k) % N]) md_found = (md_ptr + k) % N;
                    if (md_found >= 0) begin
                        md_wr = m_write[md_found];
                        md_addr = m_addr[md_found*AW +: AW];
                        md_wdata = m_wdata[md_found*DW +: DW];
                        md_rv = 1; md_gid = md_found; md_ptr = (md_found + 1) % N; md_st = 1;
                    end
                end else if (md_st == 1) begin
                    if (req_ready) begin
                        md_rv = 0;
                        md_st = m_lock[md_gid] ? 2 : 0;
                    end
                end else begin
                    if (m_valid[md_gid]) begin
                        md_wr = m_write[md_gid];
                        md_addr = m_addr[md_gid*AW +: AW];
                        md_wdata = m_wdata[md_gid*DW +: DW];
                        md_rv = 1; md_st = 1;
                    end else if (!m_lock[md_gid]) begin
                        md_st = 0;
                    end
                end
            end
            // compare + completion monitor on the falling edge
            forever begin
                @(negedge clk);
                exp_ready = '0;
                exp_rdata = '0;
                exp_err   = 1'b0;
                if (md_st == 1 && req_ready) begin
                    exp_ready[md_gid] = 1'b1;
                    exp_rdata = req_rdata;
                    exp_err   = req_error;
                end
                chk("req_valid", 64'(req_valid), 64'(md_rv));
                chk("req_write", 64'(req_write), 64'(md_wr));
                chk("req_addr",  64'(req_addr),  64'(md_addr));
                chk("req_wdata", 64'(req_wdata), 64'(md_wdata));
                chk("grant_id",  64'(grant_id),  64'(md_gid));
                chk("busy",      64'(busy),      64'(md_st != 0));
                chk("m_ready",   64'(m_ready),   64'(exp_ready));
                chk("m_rdata",   64'(m_rdata),   64'(exp_rdata));
                chk("m_error",   64'(m_error),   64'(exp_err));
                for (int i = 0; i < N; i++) begin
                    if (m_ready[i]) begin
                        done_total[i]++;
                        grant_log.push_back(i);
                        last_rdata = m_rdata;
                        last_err   = m_error;
                    end
                end
            end
            // APB master stub
            forever begin
                @(posedge clk);
                #1;
                req_rdata = slv_rdata;
                req_error = slv_err;
                if (req_ready) begin
                    req_ready = 1'b0;
                    slv_cnt   = 0;
                end else if (slv_spur) begin
                    req_ready = 1'b1;
                    slv_spur  = 1'b0;
                end else if (req_valid) begin
                    slv_cnt++;
                    if (slv_cnt >= slv_delay) req_ready = 1'b1;
                end else begin
                    slv_cnt = 0;
                end
            end
            // requester stubs: present the next queued job until it completes
            forever begin
                @(posedge clk);
                #2;
                for (int i = 0; i < N; i++) begin
                    if (done_total[i] < pending[i]) begin
                        m_valid[i] = 1'b1;
                        m_write[i] = job_wr[i][done_total[i] - base[i]];
                        m_lock[i]  = job_lock[i][done_total[i] - base[i]];
                        m_addr[i*AW +: AW]  = job_addr[i][done_total[i] - base[i]];
                        m_wdata[i*DW +: DW] = job_wdata[i][done_total[i] - base[i]];
                    end else begin
                        m_valid[i] = 1'b0;
                        m_lock[i]  = 1'b0;
                    end
                end
            end
            // watchdog
            begin
                #400000;
                $display("FAIL watchdog: simulation did not finish, expected completion");
                $fatal(1, "watchdog");
            end
        join_none

        // reset values
        @(negedge clk);
        chk("rst_req_valid", 64'(req_valid), 64'(0));
        chk("rst_busy",      64'(busy),      64'(0));
        chk("rst_grant_id",  64'(grant_id),  64'(0));
        chk("rst_req_addr",  64'(req_addr),  64'(0));
        chk("rst_m_ready",   64'(m_ready),   64'(0));
        step();
        rst_n = 1'b1;

        // 1: single write from requester 2
        new_test();
        slv_delay = 3;
        set_job(2, 0, 1'b1, 32'h0000_0004, 32'h0000_00A5, 1'b0);
        pending[2] = done_total[2] + 1;
        step();
        @(negedge clk);
        chk("t1_valid_T", 64'(req_valid), 64'(0));
        @(negedge clk);
        chk("t1_valid_T1", 64'(req_valid), 64'(1));
        chk("t1_addr",     64'(req_addr),  64'h4);
        chk("t1_wdata",    64'(req_wdata), 64'hA5);
        chk("t1_write",    64'(req_write), 64'(1));
        chk("t1_grant",    64'(grant_id),  64'(2));
        wait_all(30, "t1_timeout");
        repeat (3) step();
        chk("t1_pulses", 64'(done_total[2] - base[2]), 64'(1));
        exp_q = '{2};
        check_order("t1_order", exp_q);

        // 2: round-robin fairness, all four requesters, two transfers each
        do_reset();
        new_test();
        slv_delay = 1;
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < 2; k++)
                set_job(i, k, k[0], 32'h100 * i + 32'(k * 4), 32'(i * 16 + k), 1'b0);
            pending[i] = done_total[i] + 2;
        end
        wait_all(200, "t2_timeout");
        exp_q = '{0, 1, 2, 3, 0, 1, 2, 3};
        check_order("t2_order", exp_q);
        for (int i = 0; i < N; i++) chk("t2_count", 64'(done_total[i] - base[i]), 64'(2));

        // 3: locked read-modify-write by requester 1 while requester 0 waits
        new_test();
        slv_delay = 2;
        set_job(1, 0, 1'b0, 32'h0, 32'h0, 1'b1);
        set_job(1, 1, 1'b1, 32'h0, 32'h5A, 1'b0);
        pending[1] = done_total[1] + 2;
        step();
        step();
        set_job(0, 0, 1'b1, 32'h40, 32'h77, 1'b0);
        pending[0] = done_total[0] + 1;
        wait_all(200, "t3_timeout");
        exp_q = '{1, 1, 0};
        check_order("t3_order", exp_q);

        // 4: read data / error routing, and a stray req_ready while idle
        new_test();
        slv_delay = 2;
        slv_rdata = 32'hDEAD_BEEF;
        slv_err   = 1'b1;
        set_job(3, 0, 1'b0, 32'h8, 32'h0, 1'b0);
        pending[3] = done_total[3] + 1;
        wait_all(50, "t4_timeout");
        chk("t4_rdata", 64'(last_rdata), 64'hDEAD_BEEF);
        chk("t4_error", 64'(last_err),   64'(1));
        step();
        slv_spur = 1'b1;
        step();
        @(negedge clk);
        chk("t4_spur_req_ready", 64'(req_ready), 64'(1));
        chk("t4_spur_m_ready",   64'(m_ready),   64'(0));
        chk("t4_spur_m_rdata",   64'(m_rdata),   64'(0));
        chk("t4_spur_m_error",   64'(m_error),   64'(0));
        step();
        slv_err   = 1'b0;
        slv_rdata = 32'h1234_5678;

        // 5: reset in the middle of a transfer
        new_test();
        slv_delay = 6;
        set_job(1, 0, 1'b1, 32'h20, 32'h99, 1'b0);
        pending[1] = done_total[1] + 1;
        step();
        step();
        chk("t5_in_xfer", 64'(busy), 64'(1));
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) pending[i] = done_total[i];
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("t5_valid", 64'(req_valid), 64'(0));
        chk("t5_busy",  64'(busy),      64'(0));
        chk("t5_grant", 64'(grant_id),  64'(0));
        step();
        new_test();
        slv_delay = 1;
        for (int i = 0; i < N; i++) begin
            set_job(i, 0, 1'b1, 32'h300 + 32'(i), 32'(i), 1'b0);
            pending[i] = done_total[i] + 1;
        end
        wait_all(100, "t5_timeout");
        exp_q = '{0, 1, 2, 3};
        check_order("t5_order", exp_q);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_req_arbiter.md
# apb_req_arbiter

Round-robin arbiter that shares the single request port of the APB master between `NUM_REQ` requesters (CPU core, DMA, debug bridge). It sits between the requesters and `apb_master` in the APB subsystem. It registers the winning requester's command, drives the master's `req_*` inputs, and routes `req_ready`/`req_rdata`/`req_error` back to the winner. A per-requester lock keeps the grant across back-to-back transfers, for example an atomic read-modify-write of a GPIO register.

## Interface
- `NUM_REQ`, default 4: number of requesters, legal range 2..8.
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width.
- `IDX_W`, default `$clog2(NUM_REQ)`: width of the grant index.

Ports:
- `clk`  in  1: the single clock.
- `rst_n`  in  1: reset, synchronous and active-low.
- `m_valid`  in  NUM_REQ: per-requester request; must stay high until that requester's `m_ready` bit pulses.
- `m_write`  in  NUM_REQ: per-requester write (1) or read (0).
- `m_lock`  in  NUM_REQ: per-requester request to keep the grant after the current transfer.
- `m_addr`  in  NUM_REQ*ADDR_W: flattened addresses; requester i uses bits [i*ADDR_W +: ADDR_W].
- `m_wdata`  in  NUM_REQ*DATA_W: flattened write data.
- `m_ready`  out  NUM_REQ: one-hot completion pulse to the granted requester.
- `m_rdata`  out  DATA_W: read data; shared by all requesters, valid only with `m_ready`.
- `m_error`  out  1: error flag; shared, valid only with `m_ready`.
- `req_valid`  out  1: request to `apb_master`.
- `req_write`  out  1: direction to `apb_master`.
- `req_addr`  out  ADDR_W: address to `apb_master`.
- `req_wdata`  out  DATA_W: write data to `apb_master`.
- `req_ready`  in  1: one-cycle completion pulse from `apb_master`.
- `req_rdata`  in  DATA_W: read data from `apb_master`, valid with `req_ready`.
- `req_error`  in  1: error from `apb_master`, valid with `req_ready`.
- `grant_id`  out  IDX_W: index of the current or most recent grant.
- `busy`  out  1: high in XFER or LOCKED.

## Operation
- The state machine has three states: IDLE, XFER and LOCKED.
- **IDLE:** if any `m_valid` is high, pick a winner by round-robin starting at pointer `ptr`. At the clock edge:
  - capture the winner's write/addr/wdata into the `req_*` registers;
  - set `grant_id` to the winner and `req_valid` to 1;
  - set `ptr` to (winner+1) mod NUM_REQ;
  - go to XFER.
- **XFER:** `req_*` are held stable. In the cycle `req_ready`=1:
  - `m_ready[grant_id]`=1, `m_rdata`=`req_rdata` and `m_error`=`req_error`, all combinational pass-through;
  - at the edge, `req_valid` goes to 0;
  - the next state is LOCKED if `m_lock[grant_id]`=1, otherwise IDLE.
- **LOCKED:** only requester `grant_id` is served; all other requesters wait.
  - If `m_valid[grant_id]`=1: capture its command and go to XFER. `ptr` is not updated.
  - Else if `m_lock[grant_id]`=0: go to IDLE.
  - Else: stay in LOCKED.
- Outside the `req_ready` cycle of XFER, `m_ready`=0, and `m_rdata`/`m_error` are driven to 0.
- `m_lock` is sampled only at the completion cycle and in LOCKED. A lock asserted during IDLE has no effect until that requester's transfer completes.
- The round-robin search wraps: with `ptr`=NUM_REQ-1 the search order is NUM_REQ-1, 0, 1, …
- `req_ready` seen in IDLE or LOCKED (a protocol error by the master) is ignored, and `m_ready` stays 0.

## Timing
- Reset values: state=IDLE, `ptr`=0, `grant_id`=0, `req_valid`=0, `req_write`=0, `req_addr`=0, `req_wdata`=0, `busy`=0, `m_ready`=0, `m_rdata`=0, `m_error`=0.
- Latency: `m_valid` rising in cycle T, with the arbiter in IDLE, gives `req_valid`=1 in T+1.
- Completion: `m_ready` is asserted in the same cycle as `req_ready`.
- Gaps between transfers:
  - unlocked: the next grant is earliest 1 cycle after completion (one IDLE cycle, so `req_valid` is low for ≥1 cycle);
  - locked: same gap, spent in LOCKED.
- Requester rules:
  - must deassert `m_valid` in the cycle after its `m_ready`, or present a new command there;
  - must not change its command while waiting for a grant.
- Reset is synchronous. `rst_n` low mid-XFER forces IDLE with `req_valid`=0 at the next edge; `apb_master` shares `rst_n`.

## Structure
- A shared package `apb_pkg` holds:
  - the `ADDR_W`/`DATA_W` defaults;
  - the `arb_state_t` enum (IDLE, XFER, LOCKED).
- One sub-module, `rr_picker`. It is purely combinational: `req_vec`+`ptr` in, `grant_onehot`+`grant_idx`+`any` out. It is reusable by later arbiters.

## Test plan
1. Single requester: requester 2 writes addr 0x0000_0004, data 0xA5; master `req_ready` 3 cycles later -> `req_valid`=1 at T+1 with addr 0x4/data 0xA5; `m_ready`=4'b0100 pulses once; `grant_id`=2.
2. Round-robin fairness: all 4 `m_valid` held high for 8 transfers, `ptr`=0 -> grant order 0,1,2,3,0,1,2,3; each requester completes 2 transfers.
3. Lock: requester 1 sets `m_lock` and issues a read then a write to 0x0; requester 0 is pending throughout -> requester 1 gets both grants with no intervening grant to requester 0; requester 0 is granted after lock drops.
4. Read/error routing: read with `req_rdata`=0xDEAD_BEEF and `req_error`=1 -> `m_rdata`=0xDEAD_BEEF and `m_error`=1 only in the `m_ready` cycle; both are 0 otherwise.
5. Reset mid-transfer: `rst_n`=0 for one cycle during XFER -> next cycle `req_valid`=0, `busy`=0, `ptr`=0; after release, requester 0 wins when all are requesting.
